// File: rtl/memory_arbiter32.sv
// memory_io32_pkg + memory_arbiter32
//
// Two-requester arbiter in front of one single-ported 32-bit memory.
// port0 = instruction fetch, port1 = data load/store. port1 wins ties
// until it has taken max_burst consecutive grants while port0 was waiting;
// then port0 gets one grant. One request is issued per cycle and the
// single-cycle response is steered back to the port that issued it.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low
//   port0_req    fetch request in          port0_ready  fetch accepted
//   port0_rsp    fetch response out
//   port1_req    data request in           port1_ready  data accepted
//   port1_rsp    data response out
//   mem_req      request to memory         mem_rsp      memory response,
//                                          one cycle after an op-bearing req

package memory_io32_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
    logic [3:0]  user_tag;
  } memory_io_req32;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [3:0]  user_tag;
  } memory_io_rsp32;

  localparam memory_io_req32 memory_io_no_req32 = '0;
  localparam memory_io_rsp32 memory_io_no_rsp32 = '0;
endpackage

module memory_arbiter32
  import memory_io32_pkg::*;
#(
  parameter int unsigned max_burst = 4,
  parameter int unsigned cnt_w     = $clog2(max_burst + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  memory_io_req32 port0_req,
  output logic           port0_ready,
  output memory_io_rsp32 port0_rsp,
  input  memory_io_req32 port1_req,
  output logic           port1_ready,
  output memory_io_rsp32 port1_rsp,
  output memory_io_req32 mem_req,
  input  memory_io_rsp32 mem_rsp
);

  localparam logic [cnt_w-1:0] BURST_MAX = cnt_w'(max_burst);

  logic [cnt_w-1:0] burst_cnt;
  logic             inflight_valid;
  logic             inflight_id;

  logic             v0, v1;
  logic             gnt0, gnt1;
  logic             has_op;
  memory_io_req32   sel_req;

  // Raw grant decision. Kept free of reset so the state flops never see the
  // async reset on their data path; outputs are gated separately below.
  always_comb begin
    v0      = port0_req.valid;
    v1      = port1_req.valid;
    gnt1    = v1 && (!v0 || (burst_cnt < BURST_MAX));
    gnt0    = v0 && !gnt1;
    sel_req = memory_io_no_req32;
    if (gnt1)      sel_req = port1_req;
    else if (gnt0) sel_req = port0_req;
    // no_req carries no op bits, so this is zero when nothing is granted
    has_op  = (|sel_req.do_read) || (|sel_req.do_write);
  end

  // Outputs are forced idle for as long as reset is held low.
  always_comb begin
    port0_ready = reset && gnt0;
    port1_ready = reset && gnt1;
    mem_req     = reset ? sel_req : memory_io_no_req32;
    port0_rsp   = memory_io_no_rsp32;
    port1_rsp   = memory_io_no_rsp32;
    // A response with nothing in flight is stale (e.g. across reset): drop it.
    if (reset && mem_rsp.valid && inflight_valid) begin
      if (inflight_id) port1_rsp = mem_rsp;
      else             port0_rsp = mem_rsp;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt      <= '0;
      inflight_valid <= 1'b0;
      inflight_id    <= 1'b0;
    end else begin
      // burst_cnt counts port1 wins that made a waiting port0 wait longer
      if (gnt1 && v0) begin
        if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
      end else if (gnt0 || !v0) begin
        burst_cnt <= '0;
      end
      // Memory answers exactly one cycle later, so one tracking slot,
      // rewritten every cycle, is enough for full throughput.
      inflight_valid <= has_op;
      if (has_op) inflight_id <= gnt1;
    end
  end

endmodule
